// File: rtl/mux_scan.sv
// Registered N-channel word multiplexer with manual select and an auto-scan mode
// that rotates through an enable-masked channel set, holding each for DWELL cycles.
module mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 3,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       en_mask,
  output logic [WIDTH-1:0]          led,
  output logic [SEL_W-1:0]          cur_ch,
  output logic                      valid,
  output logic                      step
);

  localparam int NSLOT = 1 << SEL_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  // Every index representable on SEL_W gets a slot; slots past CHANNELS read as
  // zero, disabled and out of range, so no select ever needs a bounds check.
  logic [WIDTH-1:0] word_pad [NSLOT];
  logic [NSLOT-1:0] en_pad;
  logic [NSLOT-1:0] in_range;

  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < CHANNELS) begin : g_real
        assign word_pad[gi] = data_in[gi*WIDTH +: WIDTH];
        assign en_pad[gi]   = en_mask[gi];
        assign in_range[gi] = 1'b1;
      end else begin : g_fill
        assign word_pad[gi] = '0;
        assign en_pad[gi]   = 1'b0;
        assign in_range[gi] = 1'b0;
      end
    end
  endgenerate

  logic [SEL_W-1:0] cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             valid_q, valid_d;
  logic             step_q, step_d;

  // Next enabled channel after cur_ch_q, wrapping to the lowest enabled one.
  logic [SEL_W-1:0] lo_ch;
  logic [SEL_W-1:0] gt_ch;
  logic             gt_found;
  logic [SEL_W-1:0] nxt_ch;

  always_comb begin
    lo_ch    = '0;
    gt_ch    = '0;
    gt_found = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (en_mask[k]) begin
        lo_ch = SEL_W'(k);
        if (k > int'(cur_ch_q)) begin
          gt_ch    = SEL_W'(k);
          gt_found = 1'b1;
        end
      end
    end
    nxt_ch = gt_found ? gt_ch : lo_ch;
  end

  always_comb begin
    cur_ch_d = cur_ch_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    valid_d  = valid_q;
    step_d   = 1'b0;
    if (!mode) begin
      cur_ch_d = sel;
      cnt_d    = '0;
      led_d    = word_pad[sel];
      valid_d  = in_range[sel];
    end else if (en_mask == '0) begin
      cnt_d   = '0;
      led_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (!en_pad[cur_ch_q]) begin
        cur_ch_d = nxt_ch;
        cnt_d    = '0;
        step_d   = 1'b1;
      end else if (cnt_q == CNT_W'(DWELL - 1)) begin
        cur_ch_d = nxt_ch;
        cnt_d    = '0;
        step_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      led_d   = word_pad[cur_ch_d];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ch_q <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      valid_q  <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      cur_ch_q <= cur_ch_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
      valid_q  <= valid_d;
      step_q   <= step_d;
    end
  end

  assign led    = led_q;
  assign cur_ch = cur_ch_q;
  assign valid  = valid_q;
  assign step   = step_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: directed vectors with literal checks plus a per-cycle
// comparison against a behavioural model of the channel scan.
module tb_mux_scan;
  localparam int WIDTH = 4;
  localparam int CH    = 3;
  localparam int SEL_W = 2;
  localparam int DW    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [CH*WIDTH-1:0] data_in;
  logic              mode;
  logic [SEL_W-1:0]  sel;
  logic [CH-1:0]     en_mask;
  logic [WIDTH-1:0]  led;
  logic [SEL_W-1:0]  cur_ch;
  logic              valid;
  logic              step;

  int tests = 0;
  int fails = 0;

  mux_scan #(.WIDTH(WIDTH), .CHANNELS(CH), .SEL_W(SEL_W), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .mode(mode), .sel(sel),
    .en_mask(en_mask), .led(led), .cur_ch(cur_ch), .valid(valid), .step(step)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: which channel is shown, how long it has been shown.
  int m_ch = 0, m_held = 0, m_led = 0, m_valid = 0, m_step = 0;
  bit m_live = 0;

  function automatic int word_of(int k);
    return int'((data_in >> (k * WIDTH)) & 12'hF);
  endfunction

  function automatic int next_of(int c);
    for (int k = c + 1; k < CH; k++) if (en_mask[k]) return k;
    for (int k = 0; k < CH; k++) if (en_mask[k]) return k;
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ch = 0; m_held = 0; m_led = 0; m_valid = 0; m_step = 0;
    end else if (!mode) begin
      m_ch = int'(sel); m_held = 0; m_step = 0;
      m_valid = (m_ch < CH) ? 1 : 0;
      m_led = (m_ch < CH) ? word_of(m_ch) : 0;
    end else if (en_mask == '0) begin
      m_held = 0; m_led = 0; m_valid = 0; m_step = 0;
    end else begin
      if (m_ch >= CH || !en_mask[m_ch] || m_held == DW - 1) begin
        m_ch = next_of(m_ch >= CH ? -1 : m_ch);
        m_held = 0; m_step = 1;
      end else begin
        m_held++; m_step = 0;
      end
      m_led = word_of(m_ch); m_valid = 1;
    end
    m_live = 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_led", 32'(led), 32'(m_led));
      check("model_cur_ch", 32'(cur_ch), 32'(m_ch));
      check("model_valid", 32'(valid), 32'(m_valid));
      check("model_step", 32'(step), 32'(m_step));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect4(input string name, input int e_led, input int e_ch,
                         input int e_valid, input int e_step);
    $display("[TB] %s: led=%0h cur_ch=%0d valid=%0d step=%0d", name, led, cur_ch, valid, step);
    check({name, "_led"}, 32'(led), 32'(e_led));
    check({name, "_cur_ch"}, 32'(cur_ch), 32'(e_ch));
    check({name, "_valid"}, 32'(valid), 32'(e_valid));
    check({name, "_step"}, 32'(step), 32'(e_step));
  endtask

  initial begin
    logic [3:0] man_led [4];
    man_led[0] = 4'hB; man_led[1] = 4'hF; man_led[2] = 4'hE; man_led[3] = 4'h0;

    rst = 1; mode = 1; sel = 0; en_mask = 3'b111; data_in = 12'hEFB;
    cyc(2);
    expect4("reset", 0, 0, 0, 0);
    rst = 0;
    cyc(3);
    rst = 1;
    cyc(1);
    expect4("reset_mid_scan", 0, 0, 0, 0);
    rst = 0;

    mode = 0;
    for (int s = 0; s < 4; s++) begin
      sel = SEL_W'(s);
      cyc(1);
      expect4($sformatf("manual_sel%0d", s), int'(man_led[s]), s, (s < CH) ? 1 : 0, 0);
      cyc(3);
    end

    sel = 0;
    cyc(1);
    mode = 1; en_mask = 3'b111;
    cyc(3);
    expect4("auto_hold_ch0", 'hB, 0, 1, 0);
    cyc(1);
    expect4("auto_to_ch1", 'hF, 1, 1, 1);
    cyc(1);
    expect4("auto_ch1_held", 'hF, 1, 1, 0);
    cyc(3);
    expect4("auto_to_ch2", 'hE, 2, 1, 1);
    cyc(4);
    expect4("auto_wrap_ch0", 'hB, 0, 1, 1);

    en_mask = 3'b101;
    cyc(4);
    expect4("masked_to_ch2", 'hE, 2, 1, 1);
    cyc(4);
    expect4("masked_to_ch0", 'hB, 0, 1, 1);
    cyc(4);
    expect4("masked_to_ch2b", 'hE, 2, 1, 1);
    cyc(1);
    en_mask = 3'b010;
    cyc(1);
    expect4("mask_drop_jump", 'hF, 1, 1, 1);

    en_mask = 3'b000;
    cyc(1);
    expect4("empty_mask", 0, 1, 0, 0);
    cyc(2);
    expect4("empty_mask_hold", 0, 1, 0, 0);
    en_mask = 3'b001;
    cyc(1);
    expect4("empty_recover", 'hB, 0, 1, 1);

    mode = 0; sel = 3;
    cyc(1);
    expect4("manual_oob", 0, 3, 0, 0);
    mode = 1; en_mask = 3'b111;
    cyc(1);
    expect4("switch_jump", 'hB, 0, 1, 1);
    data_in = 12'hEF7;
    cyc(1);
    expect4("data_follow", 'h7, 0, 1, 0);

    // Single enabled channel still pulses step each dwell.
    en_mask = 3'b100;
    cyc(1);
    expect4("single_jump", 'hE, 2, 1, 1);
    cyc(4);
    expect4("single_repeat", 'hE, 2, 1, 1);

    en_mask = 3'b111;
    for (int i = 0; i < 20; i++) begin
      data_in = 12'($urandom);
      if (i == 10) en_mask = 3'b011;
      cyc(1);
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
